// File: rtl/modexp_seq_decrypt.sv
// Sequential square-and-multiply modular exponentiation r = c^d mod n, one modular op per cycle.
// Optional MODEXP_LEADING_ZERO_SKIP_EN: start the exponent scan at the MSB set bit of d.
module modexp_seq_decrypt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  input  logic [W-1:0] n,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] r,
  output logic         busy,
  output logic         err
);

  localparam int KW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, SQUARE, MULT, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    cb, db, nb, acc;
  logic [KW-1:0]   k, start_k;
  logic            err_q;
  logic            accept, start_done, k_dec;
  logic [W-1:0]    one_mod, c_mod, prod_mod;
  logic [2*W-1:0]  prod;

`ifdef MODEXP_LEADING_ZERO_SKIP_EN
  function automatic logic [KW-1:0] msb_idx(input logic [W-1:0] v);
    msb_idx = '0;
    for (int unsigned i = 0; i < W; i++)
      if (v[i]) msb_idx = KW'(i);
  endfunction

  always_comb begin
    start_k    = msb_idx(d);
    start_done = (d == '0);
  end
`else
  always_comb begin
    start_k    = KW'(W - 1);
    start_done = 1'b0;
  end
`endif

  always_comb begin
    accept  = in_valid && (state == IDLE);
    one_mod = (n == W'(1)) ? '0 : W'(1);
    c_mod   = (n == '0) ? '0 : (c % n);
    if (state == MULT) prod = {{W{1'b0}}, acc} * {{W{1'b0}}, cb};
    else               prod = {{W{1'b0}}, acc} * {{W{1'b0}}, acc};
    prod_mod = (nb == '0) ? '0 : W'(prod % {{W{1'b0}}, nb});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    k_dec     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_nxt = ((n == '0) || start_done) ? DONE : SQUARE;
      end
      SQUARE: begin
        busy = 1'b1;
        if (db[k])           state_nxt = MULT;
        else if (k == '0)    state_nxt = DONE;
        else                 k_dec     = 1'b1;
      end
      MULT: begin
        busy = 1'b1;
        if (k == '0) state_nxt = DONE;
        else begin
          state_nxt = SQUARE;
          k_dec     = 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    r   = out_valid ? acc : '0;
    err = out_valid & err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cb    <= '0;
      db    <= '0;
      nb    <= '0;
      acc   <= '0;
      k     <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        cb    <= c_mod;
        db    <= d;
        nb    <= n;
        k     <= start_k;
        // n==0 flags err and reports zero; otherwise acc starts at 1 reduced by n
        acc   <= (n == '0) ? '0 : one_mod;
        err_q <= (n == '0);
      end else if (state == SQUARE || state == MULT) begin
        acc <= prod_mod;
      end
      if (k_dec) k <= k - KW'(1);
    end
  end

endmodule

// File: tb/tb_modexp_seq_decrypt.sv
// Scoreboard bench for modexp_seq_decrypt: reference by repeated multiplication, latency from the formula.
module tb_modexp_seq_decrypt;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] c = '0, d = '0, n = '0;
  logic         in_ready, out_valid, busy, err;
  logic [W-1:0] r;

  modexp_seq_decrypt #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .c(c), .d(d), .n(n), .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  function automatic exp_t model(input logic [W-1:0] cc, input logic [W-1:0] dd, input logic [W-1:0] nn);
    exp_t   e;
    longint a;
    int     pc, msb;
    pc = 0;
    msb = -1;
    for (int i = 0; i < W; i++) if (dd[i]) begin pc++; msb = i; end
    if (nn == 0) begin
      e.r = '0; e.err = 1'b1; e.lat = 0;
      return e;
    end
    a = 1 % longint'(nn);
    for (int i = 0; i < int'(dd); i++) a = (a * longint'(cc)) % longint'(nn);
    e.r = W'(a);
    e.err = 1'b0;
`ifdef MODEXP_LEADING_ZERO_SKIP_EN
    e.lat = (msb < 0) ? 0 : msb + 1 + pc;
`else
    e.lat = W + pc;
`endif
    return e;
  endfunction

  task automatic send(input logic [W-1:0] cc, input logic [W-1:0] dd, input logic [W-1:0] nn);
    checks++;
    if (in_ready !== 1'b1) $display("FAIL in_ready_idle got %b exp 1", in_ready);
    else passed++;
    c = cc; d = dd; n = nn;
    in_valid = 1'b1;
    sb.push_back(model(cc, dd, nn));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(input string name);
    exp_t e;
    int   lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      checks++;
      if (in_ready !== 1'b0) $display("FAIL %s in_ready_busy got %b exp 0", name, in_ready);
      else passed++;
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1) $display("FAIL %s timeout out_valid got %b exp 1", name, out_valid);
    else passed++;
    checks++;
    if (r !== e.r) $display("FAIL %s r got %0d exp %0d", name, r, e.r);
    else passed++;
    checks++;
    if (err !== e.err) $display("FAIL %s err got %b exp %b", name, err, e.err);
    else passed++;
    checks++;
    if (lat !== e.lat) $display("FAIL %s latency got %0d exp %0d", name, lat, e.lat);
    else passed++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s release got ov=%b ir=%b exp ov=0 ir=1", name, out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({in_ready, out_valid, busy, err} !== 4'b1000 || r !== '0)
      $display("FAIL reset got ir=%b ov=%b busy=%b err=%b r=%0d exp ir=1 ov=0 busy=0 err=0 r=0",
               in_ready, out_valid, busy, err, r);
    else passed++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    send(8'd7, 8'd7, 8'd127);
    checks++;
    if (busy !== 1'b1) $display("FAIL busy_square got %b exp 1", busy);
    else passed++;
    collect("c7d7n127");
    send(8'd7, 8'd4, 8'd127);    collect("c7d4n127");
    send(8'd31, 8'd7, 8'd33);    collect("rsa33");
    send(8'd200, 8'd1, 8'd127);  collect("base_reduce");
    send(8'd9, 8'd0, 8'd127);    collect("d_zero");
    send(8'd9, 8'd5, 8'd1);      collect("n_one");
    send(8'd9, 8'd5, 8'd0);
    checks++;
    if (busy !== 1'b0) $display("FAIL n_zero_busy got %b exp 0", busy);
    else passed++;
    collect("n_zero");
    send(8'd255, 8'd255, 8'd255); collect("all_ones");
  endtask

  task automatic test_stall();
    exp_t e;
    int   w;
    send(8'd7, 8'd7, 8'd127);
    w = 0;
    while (out_valid !== 1'b1 && w < 200) begin @(posedge clk); #1; w++; end
    e = sb.pop_front();
    for (int i = 0; i < 20; i++) begin
      in_valid = (i == 5);
      c = 8'd3; d = 8'd3; n = 8'd11;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || r !== e.r || in_ready !== 1'b0)
        $display("FAIL stall cyc %0d got ov=%b r=%0d ir=%b exp ov=1 r=%0d ir=0", i, out_valid, r, in_ready, e.r);
      else passed++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
        $display("FAIL stall_no_queue got ir=%b busy=%b ov=%b exp ir=1 busy=0 ov=0", in_ready, busy, out_valid);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    send(8'd7, 8'd7, 8'd127);
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b1) $display("FAIL mid_busy got %b exp 1", busy);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || r !== '0 || busy !== 1'b0)
      $display("FAIL mid_reset got ir=%b ov=%b r=%0d busy=%b exp ir=1 ov=0 r=0 busy=0", in_ready, out_valid, r, busy);
    else passed++;
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'd7, 8'd7, 8'd127);
    collect("reissue");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] rc, rd, rn;
    for (int i = 0; i < 12; i++) begin
      rc = W'($urandom_range(0, 255));
      rd = W'($urandom_range(0, 255));
      rn = (i == 3) ? '0 : W'($urandom_range(1, 255));
      send(rc, rd, rn);
      collect("random");
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
